// File: rtl/dbuf_arbiter.sv
// dbuf_arbiter: two-requester round-robin arbiter and zero-fill sequencer for
// the single-port dbuf (1-cycle registered read). Sole driver of the dbuf port.
// Optional feature macro: DBUF_ARB_BOUNDCHK_EN (out-of-range address guard + sticky err).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_ARB   | normal operation, at most one requester access per cycle
// ST_CLEAR | zero-fill sweep of dbuf[0..BOUND], both requesters blocked
module dbuf_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int BOUND = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_didx,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_di,
  output logic          err
);

  localparam logic [AW-1:0] BOUND_A = AW'(BOUND);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_r1_q;

  logic          acc;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_oob;

  // Round-robin grant: a lone requester wins, a tie goes to the one not granted last.
  // A clr_start cycle grants nobody so the sweep starts from a quiet port.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (state_q == ST_ARB && !clr_start) begin
      if (r0_req && (!r1_req || last_r1_q)) begin
        r0_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end
    end
  end

  assign acc       = r0_gnt | r1_gnt;
  assign acc_we    = r1_gnt ? r1_we    : r0_we;
  assign acc_addr  = r1_gnt ? r1_addr  : r0_addr;
  assign acc_wdata = r1_gnt ? r1_wdata : r0_wdata;

`ifdef DBUF_ARB_BOUNDCHK_EN
  assign acc_oob = acc && (acc_addr > BOUND_A);
`else
  assign acc_oob = 1'b0;
`endif

  // Next-state, sweep counter and dbuf port mux (idle port reads address 0).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    mem_rw   = 1'b0;
    mem_didx = '0;
    mem_din  = '0;
    case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
        end else if (acc) begin
          mem_din = acc_wdata;
          if (!acc_oob) begin
            mem_rw   = acc_we;
            mem_didx = acc_addr;
          end
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        mem_rw   = 1'b1;
        mem_didx = cnt_q;
        if (cnt_q == BOUND_A) begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
    endcase
  end

  // State, sweep counter, round-robin pointer and read-response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      cnt_q     <= '0;
      last_r1_q <= 1'b1;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (acc) begin
        last_r1_q <= r1_gnt;
      end
      r0_rvalid <= r0_gnt && !r0_we;
      r1_rvalid <= r1_gnt && !r1_we;
    end
  end

`ifdef DBUF_ARB_BOUNDCHK_EN
  logic oob_rd_q;
  logic err_q;

  // Remember an out-of-range read so its response is forced to zero; err is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_rd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      oob_rd_q <= acc_oob && !acc_we;
      err_q    <= err_q | acc_oob;
    end
  end

  assign err      = err_q;
  assign r0_rdata = oob_rd_q ? '0 : mem_di;
  assign r1_rdata = oob_rd_q ? '0 : mem_di;
`else
  assign err      = 1'b0;
  assign r0_rdata = mem_di;
  assign r1_rdata = mem_di;
`endif

endmodule

// File: tb/tb_dbuf_arbiter.sv
// Bench for dbuf_arbiter: dbuf model, reference model of the arbiter and its
// memory contents, directed scenarios with literal expectations, random traffic.
module tb_dbuf_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int BOUND = 7;
`ifdef DBUF_ARB_BOUNDCHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          r0_req = 1'b0, r0_we = 1'b0, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r0_rdata;
  logic          r1_req = 1'b0, r1_we = 1'b0, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0, r1_rdata;
  logic [DW-1:0] mem_din, mem_di;
  logic [AW-1:0] mem_didx;
  logic          mem_rw;
  logic          err;

  always #5 clk = ~clk;

  dbuf_arbiter #(.AW(AW), .DW(DW), .BOUND(BOUND)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_din(mem_din), .mem_didx(mem_didx), .mem_rw(mem_rw), .mem_di(mem_di),
    .err(err)
  );

  // dbuf: single port, registered read
  logic [DW-1:0] dbuf [0:255];
  always @(posedge clk) begin
    if (mem_rw) dbuf[mem_didx[7:0]] <= mem_din;
    mem_di <= dbuf[mem_didx[7:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [DW-1:0] ref_mem [0:255];
  bit            m_clear = 1'b0;
  int            m_cnt = 0;
  bit            m_last1 = 1'b1;
  bit            m_rv0 = 1'b0, m_rv1 = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  bit            started = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dbuf[i]    = 32'hA5A5A5A5;
      ref_mem[i] = 32'hA5A5A5A5;
    end
  end

  always @(posedge clk) started <= 1'b1;

  int            win;
  bit            e_g0, e_g1, e_rw, din_chk, oob, we;
  logic [AW-1:0] e_didx, a;
  logic [DW-1:0] e_din, wd, rdv;

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (started) begin
      e_g0 = 0; e_g1 = 0; e_rw = 0; e_didx = '0; e_din = '0; din_chk = 1;
      win = -1; oob = 0; a = '0; we = 0; wd = '0;
      if (m_clear) begin
        e_rw = 1; e_didx = 16'(m_cnt);
      end else if (!clr_start) begin
        if (r0_req && r1_req) win = m_last1 ? 0 : 1;
        else if (r0_req)      win = 0;
        else if (r1_req)      win = 1;
      end
      if (win >= 0) begin
        a  = (win == 1) ? r1_addr  : r0_addr;
        we = (win == 1) ? r1_we    : r0_we;
        wd = (win == 1) ? r1_wdata : r0_wdata;
        e_g0 = (win == 0);
        e_g1 = (win == 1);
        oob  = BCHK && (int'(a) > BOUND);
        e_rw = we && !oob;
        if (!oob) e_didx = a;
        e_din = wd;
        din_chk = e_rw;
      end
      chk("clr_busy", 32'(clr_busy), 32'(m_clear));
      chk("r0_gnt", 32'(r0_gnt), 32'(e_g0));
      chk("r1_gnt", 32'(r1_gnt), 32'(e_g1));
      chk("mem_rw", 32'(mem_rw), 32'(e_rw));
      chk("mem_didx", 32'(mem_didx), 32'(e_didx));
      if (din_chk) chk("mem_din", mem_din, e_din);
      chk("r0_rvalid", 32'(r0_rvalid), 32'(m_rv0));
      chk("r1_rvalid", 32'(r1_rvalid), 32'(m_rv1));
      if (m_rv0) chk("r0_rdata", r0_rdata, m_rd0);
      if (m_rv1) chk("r1_rdata", r1_rdata, m_rd1);
      chk("err", 32'(err), 32'(m_err));

      rdv = oob ? '0 : ref_mem[a[7:0]];
      if (e_rw) ref_mem[e_didx[7:0]] = e_din;
      if (rst) begin
        m_clear = 0; m_cnt = 0; m_last1 = 1; m_rv0 = 0; m_rv1 = 0; m_err = 0;
      end else begin
        m_rv0 = (win == 0) && !we; m_rd0 = rdv;
        m_rv1 = (win == 1) && !we; m_rd1 = rdv;
        if (oob) m_err = 1;
        if (win >= 0) m_last1 = (win == 1);
        if (m_clear) begin
          if (m_cnt == BOUND) begin m_clear = 0; m_cnt = 0; end
          else m_cnt++;
        end else if (clr_start) begin
          m_clear = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_req = 0; r1_req = 0; clr_start = 0;
  endtask

  task automatic rd0(input logic [AW-1:0] ad, input logic [DW-1:0] ex);
    r0_req = 1; r0_we = 0; r0_addr = ad;
    @(negedge clk);
    chk("rd_gnt", 32'(r0_gnt), 32'd1);
    step();
    r0_req = 0;
    @(negedge clk);
    chk("rd_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd_data", r0_rdata, ex);
    step();
  endtask

  task automatic wr0(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    r0_req = 1; r0_we = 1; r0_addr = ad; r0_wdata = d;
    @(negedge clk);
    step();
    r0_req = 0;
  endtask

  bit g0s, g1s, done;
  int nb;

  initial begin
    // reset, two edges
    idle();
    step();
    @(negedge clk);
    chk("rst_rvalid0", 32'(r0_rvalid), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    rst = 0;

    // tie after reset: r0 first
    r0_req = 1; r0_we = 0; r0_addr = 0;
    r1_req = 1; r1_we = 0; r1_addr = 0;
    @(negedge clk);
    chk("t1_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("t1_r1_gnt0", 32'(r1_gnt), 32'd0);
    step();
    r0_req = 0;
    @(negedge clk);
    chk("t1_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("t1_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("t1_r0_rdata", r0_rdata, 32'hA5A5A5A5);
    step();
    r1_req = 0;
    @(negedge clk);
    chk("t1_r1_rvalid", 32'(r1_rvalid), 32'd1);
    step();

    // write then read-after-write from the other requester
    r0_req = 1; r0_we = 1; r0_addr = 5; r0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_wr_gnt", 32'(r0_gnt), 32'd1);
    step();
    r0_req = 0;
    r1_req = 1; r1_we = 0; r1_addr = 5;
    @(negedge clk);
    chk("t2_rd_gnt", 32'(r1_gnt), 32'd1);
    step();
    r1_req = 0;
    @(negedge clk);
    chk("t2_rvalid", 32'(r1_rvalid), 32'd1);
    chk("t2_rdata", r1_rdata, 32'hDEADBEEF);
    step();

    // continuous contention alternates, last winner was r1
    r0_req = 1; r0_we = 1; r0_addr = 1;
    r1_req = 1; r1_we = 0; r1_addr = 2;
    for (int i = 0; i < 6; i++) begin
      r0_wdata = 32'(i + 100);
      @(negedge clk);
      chk("t3_r0_gnt", 32'(r0_gnt), 32'((i % 2) == 0));
      chk("t3_r1_gnt", 32'(r1_gnt), 32'((i % 2) == 1));
      chk("t3_mem_rw", 32'(mem_rw), 32'((i % 2) == 0));
      step();
    end
    idle();

    // clear with r1 waiting
    r1_req = 1; r1_we = 0; r1_addr = 3;
    clr_start = 1;
    @(negedge clk);
    chk("t4_start_nogrant", 32'(r1_gnt), 32'd0);
    step();
    clr_start = 0;
    nb = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (clr_busy) begin
        nb++;
        chk("t4_r1_blocked", 32'(r1_gnt), 32'd0);
      end else if (nb > 0) begin
        chk("t4_gnt_after_clr", 32'(r1_gnt), 32'd1);
        done = 1;
      end
      step();
    end
    chk("t4_clr_done", 32'(done), 32'd1);
    chk("t4_busy_cycles", 32'(nb), 32'd8);
    r1_req = 0;
    for (int i = 0; i <= 7; i++) rd0(16'(i), 32'h0);

    // reset mid-clear at cnt=3
    for (int i = 0; i <= 7; i++) wr0(16'(i), 32'hA5A5A5A5);
    clr_start = 1;
    @(negedge clk);
    step();
    clr_start = 0;
    step(); step(); step();
    rst = 1;
    @(negedge clk);
    chk("t5_cnt3", 32'(mem_didx), 32'd3);
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_busy_drop", 32'(clr_busy), 32'd0);
    step();
    for (int i = 0; i <= 2; i++) rd0(16'(i), 32'h0);
    for (int i = 4; i <= 7; i++) rd0(16'(i), 32'hA5A5A5A5);

    // address beyond BOUND
    r0_req = 1; r0_we = 1; r0_addr = 8; r0_wdata = 32'h1;
    @(negedge clk);
    chk("t6_wr_rw", 32'(mem_rw), 32'(!BCHK));
    step();
    r0_req = 0;
    @(negedge clk);
    chk("t6_err", 32'(err), 32'(BCHK));
    step();
    rd0(16'd8, BCHK ? 32'h0 : 32'h1);
    @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'(BCHK));
    step();

    // random traffic
    g0s = 1; g1s = 1;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clr_start = ($urandom_range(0, 99) == 0);
      if (!r0_req || g0s) begin
        r0_req = ($urandom_range(0, 2) != 0); r0_we = 1'($urandom_range(0, 1));
        r0_addr = 16'($urandom_range(0, 15)); r0_wdata = $urandom;
      end
      if (!r1_req || g1s) begin
        r1_req = ($urandom_range(0, 2) != 0); r1_we = 1'($urandom_range(0, 1));
        r1_addr = 16'($urandom_range(0, 15)); r1_wdata = $urandom;
      end
      @(negedge clk);
      g0s = r0_gnt; g1s = r1_gnt;
      step();
    end
    rst = 0;
    idle();
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
